// File: rtl/fp_from_int.sv
// fp_from_int: signed fixed-point sample to {sign, ma[14:0], ea[7:0]} fp word with valid/ready handshake.
// Define FP_FROM_INT_FAST_EN for a single-cycle leading-zero-count normaliser instead of the iterative shifter.
module fp_from_int #(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [23:0]     o,
  output logic            is_zero
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  localparam logic [7:0] E0 = 8'(15 - FRAC_BITS);
  state_t      r_state, w_next;
  logic        r_sign;
  logic [15:0] r_mag;
  logic [3:0]  r_s;
  logic [15:0] w_ext, w_mag, w_lmag;
  logic [3:0]  w_ls;
  logic        w_early;
  logic [14:0] w_ma;
  logic [7:0]  w_e;
  always_comb begin
    w_ext   = 16'($signed(x));
    w_mag   = x[IN_W-1] ? ~w_ext + 16'd1 : w_ext;
    w_early = w_mag == 16'd0 || w_mag[15] || w_mag[14];
  end
`ifdef FP_FROM_INT_FAST_EN
  localparam logic FAST = 1'b1;
  logic [4:0] w_lz;
  always_comb begin
    w_lz = 5'd16;
    for (int i = 0; i < 16; i++) if (w_mag[i]) w_lz = 5'(15 - i);
    w_ls   = w_early ? 4'd0 : 4'(w_lz - 5'd1);
    w_lmag = w_mag << w_ls;
  end
`else
  localparam logic FAST = 1'b0;
  always_comb begin
    w_ls   = 4'd0;
    w_lmag = w_mag;
  end
`endif
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = !in_valid ? IDLE : (w_early || FAST) ? DONE : NORM;
    else if (r_state == NORM) w_next = r_mag[13] ? DONE : NORM;
    else w_next = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_mag   <= 16'd0;
      r_s     <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && in_valid) begin
        r_sign <= x[IN_W-1];
        r_mag  <= w_lmag;
        r_s    <= w_ls;
      end else if (r_state == NORM) begin
        r_mag <= r_mag << 1;
        r_s   <= r_s + 4'd1;
      end
    end
  end
  // 15-bit negation leaves 0x4000 and 0x8000 magnitudes with the encodings the multiplier expects
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    is_zero   = out_valid && r_mag == 16'd0;
    w_e       = E0 - {4'd0, r_s};
    w_ma      = r_sign ? ~r_mag[14:0] + 15'd1 : r_mag[14:0];
    o         = (out_valid && !is_zero) ? {r_sign, w_ma, w_e} : 24'd0;
  end
endmodule

// File: tb/tb_fp_from_int.sv
// tb_fp_from_int: directed and random checks of fp_from_int against an arithmetic reference model.
module tb_fp_from_int;
`ifdef FP_FROM_INT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic iv0 = 0, or0 = 0, ir0, ov0, iz0, iv8 = 0, or8 = 0, ir8, ov8, iz8;
  logic [15:0] x0 = 0, x8 = 0;
  logic [23:0] o0, o8, oo;
  logic ov, ir, iz;
  int total = 0, bad = 0, sel = 0;

  fp_from_int u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .x(x0),
                  .out_valid(ov0), .out_ready(or0), .o(o0), .is_zero(iz0));
  fp_from_int #(.IN_W(16), .FRAC_BITS(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
                  .x(x8), .out_valid(ov8), .out_ready(or8), .o(o8), .is_zero(iz8));

  always_comb begin
    ov = sel != 0 ? ov8 : ov0;
    ir = sel != 0 ? ir8 : ir0;
    iz = sel != 0 ? iz8 : iz0;
    oo = sel != 0 ? o8 : o0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] xv, input logic r);
    if (sel != 0) begin iv8 = v; x8 = xv; or8 = r; end
    else begin iv0 = v; x0 = xv; or0 = r; end
  endtask

  // value = x / 2^f; normalise |x| up to [2^14, 2^15] and express as two's-complement S16 * 2^(E-15)
  task automatic model(input int v, input int f, output logic [23:0] eo, output logic ez, output int es);
    int m, ma;
    m = v < 0 ? -v : v;
    es = 0;
    ez = (m == 0);
    if (m == 0) begin eo = 24'd0; return; end
    while (m < 16384) begin m = m * 2; es++; end
    ma = v < 0 ? (32768 - m) % 32768 : m;
    eo = {v < 0, 15'(ma), 8'(15 - f - es)};
  endtask

  task automatic conv(input int s, input int v, input int hold);
    logic [23:0] eo;
    logic ez;
    int es, lat, el;
    sel = s;
    model(v, s != 0 ? 8 : 0, eo, ez, es);
    el = FAST ? 1 : 1 + es;
    @(negedge clk);
    chk("in_ready_idle", 32'(ir), 1);
    drive(1'b1, 16'(v), 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 16'($urandom), 1'b0);
    lat = 1;
    while (!ov && lat < 40) begin @(negedge clk); lat++; end
    chk("latency", 32'(lat), 32'(el));
    chk("o", 32'(oo), 32'(eo));
    chk("is_zero", 32'(iz), 32'(ez));
    chk("in_ready_busy", 32'(ir), 0);
    if (!ez) chk("decode", 32'(int'($signed(oo[23:8]))), 32'(v * (1 << es)));
    repeat (hold) begin
      @(negedge clk);
      drive(1'b0, 16'($urandom), 1'b0);
      chk("hold_o", 32'(oo), 32'(eo));
      chk("hold_valid", 32'(ov), 1);
      chk("hold_ready", 32'(ir), 0);
    end
    drive(1'b0, 16'(v), 1'b1);
    @(negedge clk);
    drive(1'b0, 16'(v), 1'b0);
    chk("ready_after", 32'(ir), 1);
    chk("valid_after", 32'(ov), 0);
  endtask

  initial begin
    int n, seen, v;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_o", 32'(o0), 0);
    chk("rst_is_zero", 32'(iz0), 0);
    chk("rst_in_ready", 32'(ir0), 1);
    chk("rst_out_valid", 32'(ov0), 0);
    conv(0, 1, 0);
    conv(0, -1, 0);
    conv(0, 16384, 0);
    conv(0, -32768, 0);
    conv(0, 0, 0);
    conv(1, 256, 0);
    conv(0, 3, 6);
    conv(0, -16384, 2);
    conv(1, -32768, 1);
    // in_valid held high with x changing while busy: only the first x converts
    sel = 0;
    @(negedge clk);
    iv0 = 1'b1; x0 = 16'd1;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!ov0 && n < 40) begin x0 = 16'($urandom); @(negedge clk); n++; end
    chk("busy_first_o", 32'(o0), 32'h400001);
    repeat (3) begin
      x0 = 16'($urandom);
      @(negedge clk);
      chk("busy_hold_o", 32'(o0), 32'h400001);
      chk("busy_hold_ready", 32'(ir0), 0);
    end
    or0 = 1'b1; x0 = 16'($urandom);
    @(negedge clk);
    or0 = 1'b0; x0 = 16'd16384;
    chk("busy_ready_idle", 32'(ir0), 1);
    @(negedge clk);
    iv0 = 1'b0;
    chk("busy_next_valid", 32'(ov0), 1);
    chk("busy_next_o", 32'(o0), 32'h40000F);
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    // reset during a conversion of x=1 aborts it without output
    @(negedge clk);
    iv0 = 1'b1; x0 = 16'd1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_valid", 32'(ov0), 0);
    chk("abort_ready", 32'(ir0), 1);
    chk("abort_o", 32'(o0), 0);
    seen = 0;
    repeat (20) begin @(negedge clk); if (ov0) seen++; end
    chk("abort_no_stale", 32'(seen), 0);
    for (int k = 0; k < 40; k++) begin
      v = int'($signed(16'($urandom))) >>> $urandom_range(0, 15);
      conv(int'($urandom_range(0, 1)), v, int'($urandom_range(0, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
